// File: rtl/axi_burst_pkg.sv
// Shared types and constants for the AXI burst engine.
package axi_burst_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        RDATA = 3'd2,
        WDATA = 3'd3,
        BRESP = 3'd4,
        FIN   = 3'd5
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY      = 2'b00;

    // Wide enough for a burst length of 1..16 beats.
    localparam int unsigned BLEN_WIDTH = 5;

    // Ceiling log2, used for the AXI size field.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_burst_len_calc.sv
// Burst length selection: min(remaining, MAX_BURST[, beats to next 4 KB]).
// The 4 KB clip is only built when AXI_BURST_4K_SPLIT_EN is defined.
module axi_burst_len_calc
    import axi_burst_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 12,
    parameter int unsigned MAX_BURST  = 16,
    parameter int unsigned SIZE_LOG2  = 2
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [CNT_WIDTH-1:0]  remaining,
    output logic [BLEN_WIDTH-1:0] blen
);

    localparam int unsigned CW = (CNT_WIDTH > 13) ? CNT_WIDTH : 13;

    logic [CW-1:0] rem_w;
    logic [CW-1:0] lim;
    logic          unused_addr;

    assign unused_addr = ^addr;
    assign rem_w       = CW'(remaining);

`ifdef AXI_BURST_4K_SPLIT_EN
    logic [CW-1:0] to_4k;
    // Beats left before the next 4 KB page (address is beat-aligned).
    assign to_4k = CW'((13'h1000 - {1'b0, addr[11:0]}) >> SIZE_LOG2);
`endif

    // Running minimum of the clipping terms.
    always_comb begin
        lim = CW'(MAX_BURST);
        if (rem_w < lim) begin
            lim = rem_w;
        end
`ifdef AXI_BURST_4K_SPLIT_EN
        if (to_4k < lim) begin
            lim = to_4k;
        end
`endif
        blen = BLEN_WIDTH'(lim);
    end

endmodule

// File: rtl/axi_burst_engine.sv
// AXI4 INCR burst master: one local command becomes one or more bursts.
// Optional feature macro: AXI_BURST_4K_SPLIT_EN (never cross a 4 KB page).
module axi_burst_engine
    import axi_burst_pkg::*;
#(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 16,
    parameter int unsigned CNT_WIDTH  = 12,
    parameter int unsigned AXI_ID     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [CNT_WIDTH-1:0]  cmd_beats,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  done,
    output logic                  err,
    output logic [ID_WIDTH-1:0]   arid_m_inf,
    output logic [ADDR_WIDTH-1:0] araddr_m_inf,
    output logic [7:0]            arlen_m_inf,
    output logic [2:0]            arsize_m_inf,
    output logic [1:0]            arburst_m_inf,
    output logic                  arvalid_m_inf,
    input  logic                  arready_m_inf,
    input  logic [ID_WIDTH-1:0]   rid_m_inf,
    input  logic [DATA_WIDTH-1:0] rdata_m_inf,
    input  logic [1:0]            rresp_m_inf,
    input  logic                  rlast_m_inf,
    input  logic                  rvalid_m_inf,
    output logic                  rready_m_inf,
    output logic [ID_WIDTH-1:0]   awid_m_inf,
    output logic [ADDR_WIDTH-1:0] awaddr_m_inf,
    output logic [7:0]            awlen_m_inf,
    output logic [2:0]            awsize_m_inf,
    output logic [1:0]            awburst_m_inf,
    output logic                  awvalid_m_inf,
    input  logic                  awready_m_inf,
    output logic [DATA_WIDTH-1:0] wdata_m_inf,
    output logic                  wlast_m_inf,
    output logic                  wvalid_m_inf,
    input  logic                  wready_m_inf,
    input  logic [ID_WIDTH-1:0]   bid_m_inf,
    input  logic [1:0]            bresp_m_inf,
    input  logic                  bvalid_m_inf,
    output logic                  bready_m_inf
);

    localparam int unsigned SIZE_LOG2 = clog2(DATA_WIDTH / 8);

    state_t                  state, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d, step;
    logic [CNT_WIDTH-1:0]    rem_q, rem_d, blen_q;
    logic                    write_q, write_d;
    logic                    err_q, err_d;
    logic                    arvalid_q, arvalid_d;
    logic                    awvalid_q, awvalid_d;
    logic [7:0]              len_q, len_d;
    logic [7:0]              wbeat_q, wbeat_d;
    logic [BLEN_WIDTH-1:0]   blen_next;
    logic                    addr_hs, enter_addr;
    logic                    unused_ids;

    assign unused_ids = ^{rid_m_inf, bid_m_inf};

    // Length of the next burst, from the address/remaining it will start at.
    axi_burst_len_calc #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH),
        .MAX_BURST  (MAX_BURST),
        .SIZE_LOG2  (SIZE_LOG2)
    ) u_len_calc (
        .addr      (addr_d),
        .remaining (rem_d),
        .blen      (blen_next)
    );

    assign blen_q     = CNT_WIDTH'(len_q) + CNT_WIDTH'(1);
    assign step       = ADDR_WIDTH'(blen_q) << SIZE_LOG2;
    assign addr_hs    = (arvalid_q && arready_m_inf) || (awvalid_q && awready_m_inf);
    assign enter_addr = (state_d == ADDR) && (state != ADDR);

    assign arid_m_inf    = ID_WIDTH'(AXI_ID);
    assign awid_m_inf    = ID_WIDTH'(AXI_ID);
    assign arsize_m_inf  = 3'(SIZE_LOG2);
    assign awsize_m_inf  = 3'(SIZE_LOG2);
    assign arburst_m_inf = AXI_BURST_INCR;
    assign awburst_m_inf = AXI_BURST_INCR;
    assign araddr_m_inf  = addr_q;
    assign awaddr_m_inf  = addr_q;
    assign arlen_m_inf   = len_q;
    assign awlen_m_inf   = len_q;
    assign arvalid_m_inf = arvalid_q;
    assign awvalid_m_inf = awvalid_q;
    assign cmd_ready     = (state == IDLE);
    assign done          = (state == FIN);
    assign err           = err_q;

    // State register and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            len_q     <= '0;
            wbeat_q   <= '0;
        end else begin
            state     <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            write_q   <= write_d;
            err_q     <= err_d;
            arvalid_q <= arvalid_d;
            awvalid_q <= awvalid_d;
            len_q     <= len_d;
            wbeat_q   <= wbeat_d;
        end
    end

    // Next-state, bookkeeping and data-channel steering.
    always_comb begin
        state_d      = state;
        addr_d       = addr_q;
        rem_d        = rem_q;
        write_d      = write_q;
        err_d        = err_q;
        wbeat_d      = wbeat_q;
        rd_valid     = 1'b0;
        rd_data      = '0;
        rd_last      = 1'b0;
        rready_m_inf = 1'b0;
        wvalid_m_inf = 1'b0;
        wdata_m_inf  = '0;
        wlast_m_inf  = 1'b0;
        wr_ready     = 1'b0;
        bready_m_inf = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    rem_d   = cmd_beats;
                    write_d = cmd_write;
                    err_d   = 1'b0;
                    state_d = (cmd_beats == '0) ? FIN : ADDR;
                end
            end
            ADDR: begin
                if (addr_hs) begin
                    wbeat_d = '0;
                    state_d = write_q ? WDATA : RDATA;
                end
            end
            RDATA: begin
                rd_valid     = rvalid_m_inf;
                rd_data      = rdata_m_inf;
                rready_m_inf = rd_ready;
                rd_last      = rvalid_m_inf && rlast_m_inf && (rem_q == blen_q);
                if (rvalid_m_inf && rd_ready) begin
                    if (rresp_m_inf != RESP_OKAY) begin
                        err_d = 1'b1;
                    end
                    if (rlast_m_inf) begin
                        addr_d  = addr_q + step;
                        rem_d   = rem_q - blen_q;
                        state_d = (rem_q == blen_q) ? FIN : ADDR;
                    end
                end
            end
            WDATA: begin
                wvalid_m_inf = wr_valid;
                wdata_m_inf  = wr_data;
                wr_ready     = wready_m_inf;
                wlast_m_inf  = (wbeat_q == len_q);
                if (wr_valid && wready_m_inf) begin
                    if (wbeat_q == len_q) begin
                        wbeat_d = '0;
                        state_d = BRESP;
                    end else begin
                        wbeat_d = wbeat_q + 8'd1;
                    end
                end
            end
            BRESP: begin
                bready_m_inf = 1'b1;
                if (bvalid_m_inf) begin
                    if (bresp_m_inf != RESP_OKAY) begin
                        err_d = 1'b1;
                    end
                    addr_d  = addr_q + step;
                    rem_d   = rem_q - blen_q;
                    state_d = (rem_q == blen_q) ? FIN : ADDR;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Address-channel request: loaded on entry to ADDR, dropped on handshake.
    always_comb begin
        len_d     = len_q;
        arvalid_d = arvalid_q;
        awvalid_d = awvalid_q;
        if (enter_addr) begin
            len_d     = 8'(blen_next) - 8'd1;
            arvalid_d = !write_d;
            awvalid_d = write_d;
        end else if ((state == ADDR) && addr_hs) begin
            arvalid_d = 1'b0;
            awvalid_d = 1'b0;
        end
    end

endmodule
